// File: rtl/bus_map_pkg.sv
// Address map constants and region select shared by the data bus responder.
package bus_map_pkg;

  localparam logic [63:0] RAM_BASE      = 64'h0000_0000_0000_0000;
  localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;
  localparam logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] TXDATA_ADDR   = 64'h0000_0000_1000_0000;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_TIMER_CMP,
    RGN_TIMER,
    RGN_TX,
    RGN_NONE
  } region_e;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with an extra pointer bit so count spans 0..DEPTH.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot the push is about to overwrite.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder: word RAM, CLINT-style timer and a TX byte FIFO.
module data_bus_responder
  import bus_map_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            timer_irq,
  output logic            bus_error
);

  localparam int              RAM_AW    = $clog2(RAM_WORDS);
  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(RAM_WORDS * 8);

  region_e          region;
  logic [XLEN-1:0]  word_addr;
  logic             access;
  logic [XLEN-1:0]  ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;

  logic [XLEN-1:0]  mtime;
  logic [XLEN-1:0]  mtimecmp;
  logic [XLEN-1:0]  mtime_nxt;
  logic [XLEN-1:0]  mtimecmp_nxt;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             err_nxt;

  assign access    = mem_load | mem_store;
  assign word_addr = address & ~XLEN'(7);
  assign ram_idx   = address[3 +: RAM_AW];

  always_comb begin
    region = RGN_NONE;
    if ((word_addr - XLEN'(RAM_BASE)) < RAM_BYTES)  region = RGN_RAM;
    else if (word_addr == XLEN'(MTIMECMP_ADDR))     region = RGN_TIMER_CMP;
    else if (word_addr == XLEN'(MTIME_ADDR))        region = RGN_TIMER;
    else if (word_addr == XLEN'(TXDATA_ADDR))       region = RGN_TX;
  end

  always_comb begin
    load_data = '0;
    if (access) begin
      case (region)
        RGN_RAM:       load_data = ram[ram_idx];
        RGN_TIMER_CMP: load_data = mtimecmp;
        RGN_TIMER:     load_data = mtime;
        RGN_TX:        load_data = XLEN'({fifo_count, fifo_full, fifo_empty});
        default:       load_data = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (mem_store && region == RGN_RAM) ram[ram_idx] <= store_data;
  end

  always_comb begin
    mtime_nxt    = mtime + XLEN'(1);
    mtimecmp_nxt = mtimecmp;
    if (mem_store && region == RGN_TIMER)     mtime_nxt    = store_data;
    if (mem_store && region == RGN_TIMER_CMP) mtimecmp_nxt = store_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      timer_irq <= (mtime_nxt >= mtimecmp_nxt);
    end
  end

  assign fifo_push = mem_store && (region == RGN_TX);
  assign fifo_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (store_data[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (tx_data)
  );

  assign err_nxt = (access && region == RGN_NONE) || (fifo_push && fifo_full && !fifo_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bus_error <= 1'b0;
    else        bus_error <= err_nxt;
  end

endmodule
